// File: rtl/rst_seq.sv
// Reset release sequencer: asserts all domain resets, holds them, then releases domains in index order with per-domain gaps.
// Latency: release of domain i at HOLD_CYC + sum_{j<=i}(dly[j]+1) edges after the start; re-assert 1 edge after a request.
// Backpressure: none; sw_rst_req_i is a level that restarts the hold on every cycle it is seen.
module rst_seq #(
    parameter int NUM_DOMAIN = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int HOLD_CYC   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            sw_rst_req_i,
    input  logic [NUM_DOMAIN*CNT_WIDTH-1:0] stage_dly_i,
    output logic [NUM_DOMAIN-1:0]           rst_n_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int                   IDX_W     = (NUM_DOMAIN > 1) ? $clog2(NUM_DOMAIN) : 1;
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DOMAIN - 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                          state;
    logic [CNT_WIDTH-1:0]            cnt;
    logic [IDX_W-1:0]                idx;
    logic [NUM_DOMAIN*CNT_WIDTH-1:0] dly_q;
    logic [CNT_WIDTH-1:0]            cur_dly;

    // Gap field of the domain currently waiting for release.
    always_comb begin
        cur_dly = '0;
        for (int i = 0; i < NUM_DOMAIN; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_dly = dly_q[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // A software request outside HOLD is the same restart as rst_i; inside
        // HOLD it only clears cnt, which the restart values already cover.
        if (rst_i || sw_rst_req_i) begin
            state   <= S_HOLD;
            cnt     <= '0;
            idx     <= '0;
            rst_n_o <= '0;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                        idx   <= '0;
                        dly_q <= stage_dly_i;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Compare before increment so an all-ones gap never wraps.
                    if (cnt == cur_dly) begin
                        cnt <= '0;
                        for (int i = 0; i < NUM_DOMAIN; i++) begin
                            if (idx == IDX_W'(i)) begin
                                rst_n_o[i] <= 1'b1;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state  <= S_RUN;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state   <= S_HOLD;
                    cnt     <= '0;
                    idx     <= '0;
                    rst_n_o <= '0;
                    busy_o  <= 1'b1;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
